// File: rtl/conf_pkt_dispatch.sv
// Buffers 134-bit flit packets, classifies them by the head type word and
// steers each one to the config or pass-through port. Stats: CONF_DISPATCH_STATS_EN.
module conf_pkt_dispatch #(
   parameter logic [15:0] CONF_TYPE_LO = 16'h9001,
   parameter logic [15:0] CONF_TYPE_HI = 16'h9004,
   parameter int          DEPTH_LOG2   = 3
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         data_in_valid,
   input  logic [133:0] data_in,
   output logic         conf_out_valid,
   output logic [133:0] conf_out,
   output logic         pass_out_valid,
   output logic [133:0] pass_out,
   output logic         err_ovf,
   output logic [15:0]  cnt_conf_pkt,
   output logic [15:0]  cnt_pass_pkt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {I_IDLE, I_CLASSIFY, I_BODY} i_st_t;
   typedef enum logic {O_IDLE, O_STREAM} o_st_t;

   i_st_t i_st;
   o_st_t o_st;
   logic [1:0] idx;

   logic [133:0] fmem [DEPTH];
   logic [PW-1:0] f_wptr, f_rptr;
   logic f_full, f_empty, f_wr_req, f_wr, f_rd;
   logic [133:0] f_head;

   logic          tmem [DEPTH];
   logic [PW-1:0] t_wptr, t_rptr;
   logic t_full, t_empty, t_push, t_val, t_wr, t_pop, t_head;

   logic is_first, is_last, in_range, rd_last, cur_tag;

   assign is_first = data_in[133:132] == 2'b01;
   assign is_last  = data_in[133:132] == 2'b10;
   assign in_range = (data_in[31:16] >= CONF_TYPE_LO) &&
                     (data_in[31:16] <= CONF_TYPE_HI);

   assign f_full  = (f_wptr[DEPTH_LOG2] != f_rptr[DEPTH_LOG2]) &&
                    (f_wptr[DEPTH_LOG2-1:0] == f_rptr[DEPTH_LOG2-1:0]);
   assign f_empty = f_wptr == f_rptr;
   assign t_full  = (t_wptr[DEPTH_LOG2] != t_rptr[DEPTH_LOG2]) &&
                    (t_wptr[DEPTH_LOG2-1:0] == t_rptr[DEPTH_LOG2-1:0]);
   assign t_empty = t_wptr == t_rptr;

   assign f_head = fmem[f_rptr[DEPTH_LOG2-1:0]];
   assign t_head = tmem[t_rptr[DEPTH_LOG2-1:0]];

   // A pop frees a slot in the same cycle, so a full FIFO still accepts.
   assign f_wr = f_wr_req && (!f_full || f_rd);
   assign t_wr = t_push && (!t_full || t_pop);

   assign f_rd    = (o_st == O_STREAM) && !f_empty;
   assign rd_last = f_rd && (f_head[133:132] == 2'b10);
   assign t_pop   = !t_empty && ((o_st == O_IDLE) || rd_last);

   always_comb begin
      f_wr_req = 1'b0;
      t_push   = 1'b0;
      t_val    = 1'b0;
      unique case (i_st)
         I_IDLE: f_wr_req = data_in_valid && is_first;
         I_CLASSIFY: begin
            f_wr_req = data_in_valid;
            if (data_in_valid && (idx == 2'd2)) begin
               t_push = 1'b1;
               t_val  = in_range;
            end else if (data_in_valid && is_last) begin
               t_push = 1'b1;
            end
         end
         I_BODY: f_wr_req = data_in_valid;
         default: f_wr_req = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         i_st <= I_IDLE;
         idx  <= 2'd0;
      end else begin
         unique case (i_st)
            I_IDLE:
               if (data_in_valid && is_first) begin
                  idx  <= 2'd1;
                  i_st <= I_CLASSIFY;
               end
            I_CLASSIFY:
               if (data_in_valid) begin
                  if (idx == 2'd2)
                     i_st <= is_last ? I_IDLE : I_BODY;
                  else if (is_last)
                     i_st <= I_IDLE;
                  else
                     idx <= idx + 2'd1;
               end
            I_BODY:
               if (data_in_valid && is_last)
                  i_st <= I_IDLE;
            default: i_st <= I_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (f_wr)
         fmem[f_wptr[DEPTH_LOG2-1:0]] <= data_in;
      if (t_wr)
         tmem[t_wptr[DEPTH_LOG2-1:0]] <= t_val;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         f_wptr  <= '0;
         f_rptr  <= '0;
         t_wptr  <= '0;
         t_rptr  <= '0;
         err_ovf <= 1'b0;
      end else begin
         if (f_wr)
            f_wptr <= f_wptr + 1'b1;
         if (f_rd)
            f_rptr <= f_rptr + 1'b1;
         if (t_wr)
            t_wptr <= t_wptr + 1'b1;
         if (t_pop)
            t_rptr <= t_rptr + 1'b1;
         if (f_wr_req && f_full && !f_rd)
            err_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         o_st           <= O_IDLE;
         cur_tag        <= 1'b0;
         conf_out_valid <= 1'b0;
         pass_out_valid <= 1'b0;
         conf_out       <= '0;
         pass_out       <= '0;
      end else begin
         conf_out_valid <= 1'b0;
         pass_out_valid <= 1'b0;
         unique case (o_st)
            O_IDLE:
               if (!t_empty) begin
                  cur_tag <= t_head;
                  o_st    <= O_STREAM;
               end
            O_STREAM:
               if (f_rd) begin
                  if (cur_tag) begin
                     conf_out_valid <= 1'b1;
                     conf_out       <= f_head;
                  end else begin
                     pass_out_valid <= 1'b1;
                     pass_out       <= f_head;
                  end
                  // Chain straight into the next packet when its tag is ready.
                  if (rd_last) begin
                     if (!t_empty)
                        cur_tag <= t_head;
                     else
                        o_st <= O_IDLE;
                  end
               end
            default: o_st <= O_IDLE;
         endcase
      end
   end

`ifdef CONF_DISPATCH_STATS_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_conf_pkt <= 16'd0;
         cnt_pass_pkt <= 16'd0;
      end else if (o_st == O_STREAM && rd_last) begin
         if (cur_tag)
            cnt_conf_pkt <= cnt_conf_pkt + 16'd1;
         else
            cnt_pass_pkt <= cnt_pass_pkt + 16'd1;
      end
   end
`else
   assign cnt_conf_pkt = 16'd0;
   assign cnt_pass_pkt = 16'd0;
`endif

endmodule

// File: tb/tb_conf_pkt_dispatch.sv
// Bench for conf_pkt_dispatch: packet table plus scoreboard of expected
// flits, with hand sequences for reset, latency, strays and streaming.
module tb_conf_pkt_dispatch;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         data_in_valid = 1'b0;
   logic [133:0] data_in = '0;
   logic         conf_out_valid, pass_out_valid, err_ovf;
   logic [133:0] conf_out, pass_out;
   logic [15:0]  cnt_conf_pkt, cnt_pass_pkt;

   conf_pkt_dispatch dut (
      .clk(clk), .resetn(resetn),
      .data_in_valid(data_in_valid), .data_in(data_in),
      .conf_out_valid(conf_out_valid), .conf_out(conf_out),
      .pass_out_valid(pass_out_valid), .pass_out(pass_out),
      .err_ovf(err_ovf),
      .cnt_conf_pkt(cnt_conf_pkt), .cnt_pass_pkt(cnt_pass_pkt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      bit           conf;
      logic [133:0] d;
   } exp_t;

   typedef struct {
      logic [15:0] typ;
      int          n;
      bit          conf;
      int          gap;
   } vec_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;
   int   n_out = 0;
   int   n_pass = 0;
   int   first_out = -1;
   int   last_out = -1;
   int   conf_cyc[$];
   int   t0 = 0;

   exp_t         m_e;
   bit           m_gc;
   logic [133:0] m_got;

   always @(negedge clk) begin
      if (resetn && (conf_out_valid || pass_out_valid)) begin
         m_gc  = conf_out_valid;
         m_got = m_gc ? conf_out : pass_out;
         n_out++;
         if (!m_gc) n_pass++;
         if (first_out < 0) first_out = cyc;
         last_out = cyc;
         if (m_gc) conf_cyc.push_back(cyc);
         total++;
         if (conf_out_valid && pass_out_valid) begin
            bad++;
            $display("FAIL excl: conf_v=1 pass_v=1, required at most one");
         end
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected: conf=%0b data=%h, required no output",
                     m_gc, m_got);
         end else begin
            m_e = sbq.pop_front();
            if (m_e.conf !== m_gc || m_e.d !== m_got) begin
               bad++;
               $display("FAIL flit: conf=%0b data=%h required conf=%0b data=%h",
                        m_gc, m_got, m_e.conf, m_e.d);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic send_flit(input logic v, input logic [133:0] d);
      @(negedge clk);
      data_in_valid = v;
      data_in       = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_flit(1'b0, '0);
   endtask

   function automatic logic [133:0] mk_flit(input int i, input int n,
                                            input logic [15:0] typ);
      logic [159:0] r;
      logic [1:0]   h;
      logic [133:0] d;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      h = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
      d = {h, r[131:0]};
      if (i == 2) d[31:16] = typ;
      return d;
   endfunction

   task automatic send_pkt(input logic [15:0] typ, input int n,
                           input bit conf, input int gap, input bit push);
      logic [133:0] f[$];
      exp_t e;
      for (int i = 0; i < n; i++) f.push_back(mk_flit(i, n, typ));
      if (push) begin
         for (int i = 0; i < n; i++) begin
            e.conf = conf;
            e.d    = f[i];
            sbq.push_back(e);
         end
      end
      for (int i = 0; i < n; i++) begin
         if (i > 0 && gap > 0) idle(gap);
         send_flit(1'b1, f[i]);
         if (i == 0) t0 = cyc + 1;
      end
   endtask

   task automatic drain(input string nm);
      int k;
      send_flit(1'b0, '0);
      k = 0;
      while (sbq.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_drain_left"}, sbq.size(), 0);
      idle(4);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      resetn = 1'b0;
      sbq.delete();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   vec_t vt[$];
   int   base;

   initial begin
      vt = '{
         '{16'h9003, 5, 1'b1, 0},
         '{16'h0800, 4, 1'b0, 0},
         '{16'h9000, 3, 1'b0, 0},
         '{16'h9005, 3, 1'b0, 0},
         '{16'h9001, 3, 1'b1, 0},
         '{16'h9004, 4, 1'b1, 0},
         '{16'h9001, 2, 1'b0, 0},
         '{16'hFFFF, 6, 1'b0, 0},
         '{16'h9002, 3, 1'b1, 2},
         '{16'h0000, 7, 1'b0, 1}
      };

      repeat (3) @(negedge clk);
      chk("rst0_conf_v", conf_out_valid, 0);
      chk("rst0_pass_v", pass_out_valid, 0);
      chk("rst0_err", err_ovf, 0);
      chk("rst0_cnt_c", cnt_conf_pkt, 0);
      chk("rst0_cnt_p", cnt_pass_pkt, 0);
      resetn = 1'b1;

      send_pkt(16'h9003, 6, 1'b1, 0, 1'b1);
      @(negedge clk);
      #2;
      chk("mid_busy", conf_out_valid, 1);
      resetn = 1'b0;
      data_in_valid = 1'b0;
      sbq.delete();
      #1;
      chk("rst1_conf_v", conf_out_valid, 0);
      chk("rst1_conf_d", |conf_out, 0);
      chk("rst1_pass_v", pass_out_valid, 0);
      chk("rst1_err", err_ovf, 0);
      send_flit(1'b1, mk_flit(1, 6, 16'h0));
      @(negedge clk);
      resetn = 1'b1;
      base = n_out;
      idle(8);
      chk("rst_flushed", n_out - base, 0);
      send_pkt(16'h0800, 3, 1'b0, 0, 1'b1);
      drain("post_rst");

      conf_cyc.delete();
      base = n_pass;
      send_pkt(16'h9003, 5, 1'b1, 0, 1'b1);
      drain("lat");
      chk("lat_n", conf_cyc.size(), 5);
      if (conf_cyc.size() == 5) begin
         chk("lat_first", conf_cyc[0], t0 + 4);
         chk("lat_last", conf_cyc[4], t0 + 8);
      end
      chk("lat_no_pass", n_pass - base, 0);

      base = n_out;
      send_pkt(16'h1234, 2, 1'b0, 0, 1'b1);
      send_flit(1'b1, {2'b11, 132'h5});
      send_flit(1'b1, {2'b10, 132'h6});
      idle(2);
      send_flit(1'b1, {2'b11, 132'h7});
      drain("stray");
      idle(6);
      chk("stray_cnt", n_out - base, 2);

      for (int i = 0; i < vt.size(); i++)
         send_pkt(vt[i].typ, vt[i].n, vt[i].conf, vt[i].gap, 1'b1);
      drain("table");

      pulse_reset();
      n_out = 0;
      first_out = -1;
      for (int i = 0; i < 20; i++)
         send_pkt((i % 2 == 0) ? 16'h9002 : 16'h1234, 3, (i % 2 == 0), 0, 1'b1);
      drain("stream");
      chk("stream_n", n_out, 60);
      chk("stream_span", last_out - first_out + 1, 60);
      chk("stream_err", err_ovf, 0);
`ifdef CONF_DISPATCH_STATS_EN
      chk("cnt_conf", cnt_conf_pkt, 10);
      chk("cnt_pass", cnt_pass_pkt, 10);
`else
      chk("cnt_conf", cnt_conf_pkt, 0);
      chk("cnt_pass", cnt_pass_pkt, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
